// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and constants for the single-port memory arbiter.
//   The grant encoding is also used by the controller's stall logic, so
//   the state values are pinned to named constants here.
package mem_arbiter_pkg;

  // Grant encoding shared with the controller
  localparam logic [1:0] GRANT_NONE  = 2'd0;
  localparam logic [1:0] GRANT_DATA  = 2'd1;
  localparam logic [1:0] GRANT_FETCH = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = GRANT_NONE,
    GNT_D = GRANT_DATA,
    GNT_F = GRANT_FETCH
  } arb_state_t;

  // Round-robin pick: with both requesters pending, whoever was not
  // served last gets the port.
  function automatic arb_state_t pickGrant(input logic fetchReq,
                                           input logic dataReq,
                                           input logic lastD);
    arb_state_t next;
    next = IDLE;
    if (fetchReq && dataReq) begin
      next = lastD ? GNT_F : GNT_D;
    end else if (dataReq) begin
      next = GNT_D;
    end else if (fetchReq) begin
      next = GNT_F;
    end
    return next;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between instruction fetch and the data path
//   (loads/stores). The grant is registered; the port strobes follow the
//   current grant combinationally and honour the memory's busy handshake.
//   A wait counter aborts grants stuck on busy for TIMEOUT cycles.
//
// Ports
//   clock, reset        : system clock, synchronous active-high reset
//   if_req/if_addr      : fetch request and address
//   if_rdata/if_ready   : fetched word, fetch completes this cycle
//   d_read/d_write      : load / store request (store wins if both)
//   d_addr/d_wdata      : data address and store data
//   d_rdata/d_ready     : load data, data access completes this cycle
//   m_read/m_write      : memory strobes
//   m_addr/m_wdata      : memory address and write data
//   m_rdata/m_busy      : memory read data, memory not done yet
//   stall               : a request is pending and not completing
//   m_err               : one-cycle pulse when a grant is aborted
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [NBITS-1:0] if_addr,
  output logic [NBITS-1:0] if_rdata,
  output logic             if_ready,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [NBITS-1:0] d_addr,
  input  logic [NBITS-1:0] d_wdata,
  output logic [NBITS-1:0] d_rdata,
  output logic             d_ready,
  output logic             m_read,
  output logic             m_write,
  output logic [NBITS-1:0] m_addr,
  output logic [NBITS-1:0] m_wdata,
  input  logic [NBITS-1:0] m_rdata,
  input  logic             m_busy,
  output logic             stall,
  output logic             m_err
);

  // A zero TIMEOUT disables the abort; the counter still needs one bit.
  localparam bit             TIMEOUT_ON = (TIMEOUT > 0);
  localparam int             CNT_W      = TIMEOUT_ON ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // The counter holds the busy cycles already seen, so the abort fires
  // on the busy cycle that makes the run TIMEOUT long.
  localparam logic [CNT_W-1:0] ABORT_AT = TIMEOUT_ON ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_t       state_q;
  logic             lastD_q;
  logic [CNT_W-1:0] waitCnt_q;

  logic dReq;
  logic dataGnt;
  logic grantHeld;
  logic accessDone;
  logic timeoutHit;

  // Port muxing, completion/abort detection, ready and stall generation.
  always_comb begin
    dReq       = d_read | d_write;
    dataGnt    = (state_q == GNT_D);
    m_read     = 1'b0;
    m_write    = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    grantHeld  = 1'b0;
    if_rdata   = m_rdata;
    d_rdata    = m_rdata;

    case (state_q)
      GNT_D: begin
        m_addr    = d_addr;
        m_wdata   = d_wdata;
        m_write   = d_write;
        m_read    = d_read & ~d_write;
        grantHeld = dReq;
      end
      GNT_F: begin
        m_addr    = if_addr;
        m_read    = 1'b1;
        grantHeld = if_req;
      end
      default: ;
    endcase

    accessDone = grantHeld & ~m_busy;
    timeoutHit = TIMEOUT_ON & grantHeld & m_busy & (waitCnt_q == ABORT_AT);
    d_ready    = accessDone & dataGnt;
    if_ready   = accessDone & (state_q == GNT_F);
    m_err      = timeoutHit;
    stall      = (dReq & ~d_ready) | (if_req & ~if_ready);
  end

  // Grant FSM, round-robin flag and busy wait counter. On a completing
  // cycle the requester just served is not re-arbitrated, so the other
  // side is granted back-to-back if it is waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      lastD_q   <= 1'b0;
      waitCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= pickGrant(if_req, dReq, lastD_q);
          waitCnt_q <= '0;
        end
        GNT_D, GNT_F: begin
          if (!grantHeld || timeoutHit) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            if (timeoutHit) begin
              lastD_q <= ~lastD_q;
            end
          end else if (accessDone) begin
            lastD_q   <= dataGnt;
            state_q   <= pickGrant(dataGnt & if_req, ~dataGnt & dReq, dataGnt);
            waitCnt_q <= '0;
          end else if (waitCnt_q != CNT_MAX) begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          waitCnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios for reset, arbitration order, busy handling,
//   timeout abort and reset mid-grant, followed by a randomized phase in
//   which a fetch requester and a data requester share a behavioural
//   memory. Expected responses are queued at issue time and compared by
//   a monitor whenever a ready appears.
module tb_mem_arbiter;

  localparam int NBITS   = 8;
  localparam int TIMEOUT = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             if_req;
  logic [NBITS-1:0] if_addr;
  logic [NBITS-1:0] if_rdata;
  logic             if_ready;
  logic             d_read;
  logic             d_write;
  logic [NBITS-1:0] d_addr;
  logic [NBITS-1:0] d_wdata;
  logic [NBITS-1:0] d_rdata;
  logic             d_ready;
  logic             m_read;
  logic             m_write;
  logic [NBITS-1:0] m_addr;
  logic [NBITS-1:0] m_wdata;
  logic [NBITS-1:0] m_rdata;
  logic             m_busy;
  logic             stall;
  logic             m_err;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         isWrite;
  } exp_t;

  exp_t       fetchQ[$];
  exp_t       dataQ[$];
  logic [7:0] devMem[256];
  logic [7:0] refMem[256];
  int         checks = 0;
  int         errors = 0;
  bit         scoreOn = 1'b0;
  bit         randMode = 1'b0;
  int         busyRun = 0;

  mem_arbiter #(.NBITS(NBITS), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_busy(m_busy), .stall(stall), .m_err(m_err)
  );

  always #5 clock = ~clock;

  // Behavioural memory device: combinational read, write when not busy
  assign m_rdata = devMem[m_addr];

  always @(posedge clock) begin
    if (m_write && !m_busy) devMem[m_addr] = m_wdata;
  end

  // Random busy generator, runs capped well below the timeout
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (randMode) begin
        if (busyRun >= 3) m_busy = 1'b0;
        else m_busy = ($urandom_range(0, 2) == 0);
        busyRun = m_busy ? busyRun + 1 : 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [7:0] ifAddr,
                               input logic dRd, input logic dWr,
                               input logic [7:0] dAddr, input logic [7:0] dWd,
                               input logic busy);
    if_req  = ifReq;
    if_addr = ifAddr;
    d_read  = dRd;
    d_write = dWr;
    d_addr  = dAddr;
    d_wdata = dWd;
    m_busy  = busy;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    exp_t e;
    if (scoreOn) begin
      checkOutput("rand_no_err", m_err, 1'b0);
      checkOutput("rand_one_ready", if_ready & d_ready, 1'b0);
      checkOutput("rand_stall", stall,
                  ((d_read | d_write) & ~d_ready) | (if_req & ~if_ready));
      if (if_ready) begin
        checkOutput("fetch_queue", (fetchQ.size() > 0), 1'b1);
        if (fetchQ.size() > 0) begin
          e = fetchQ.pop_front();
          checkOutput("fetch_addr", m_addr, e.addr);
          checkOutput("fetch_data", if_rdata, e.data);
        end
      end
      if (d_ready) begin
        checkOutput("data_queue", (dataQ.size() > 0), 1'b1);
        if (dataQ.size() > 0) begin
          e = dataQ.pop_front();
          checkOutput("data_addr", m_addr, e.addr);
          if (e.isWrite) begin
            checkOutput("store_strobe", {m_write, m_read}, 2'b10);
            checkOutput("store_data", m_wdata, e.data);
          end else begin
            checkOutput("load_strobe", {m_write, m_read}, 2'b01);
            checkOutput("load_data", d_rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) devMem[a] = 8'($urandom);
    devMem[8'h04] = 8'h13;
    devMem[8'h08] = 8'h99;
    devMem[8'h20] = 8'h77;
    devMem[8'h24] = 8'h3C;
    devMem[8'h30] = 8'h66;

    // Reset state
    reset = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_strobes", {m_read, m_write}, 2'b00);
    checkOutput("reset_addr", m_addr, 8'h00);
    checkOutput("reset_wdata", m_wdata, 8'h00);
    checkOutput("reset_ready", {if_ready, d_ready}, 2'b00);
    checkOutput("reset_err", m_err, 1'b0);
    checkOutput("reset_stall", stall, 1'b0);

    // Single fetch, no busy
    nextCycle();
    reset = 1'b0;
    applyStimulus(1, 8'h04, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clock);
    checkOutput("f1_c0_stall", stall, 1'b1);
    checkOutput("f1_c0_read", m_read, 1'b0);
    nextCycle();
    @(negedge clock);
    checkOutput("f1_c1_read", m_read, 1'b1);
    checkOutput("f1_c1_addr", m_addr, 8'h04);
    checkOutput("f1_c1_ready", if_ready, 1'b1);
    checkOutput("f1_c1_rdata", if_rdata, 8'h13);
    checkOutput("f1_c1_stall", stall, 1'b0);
    nextCycle();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0);

    // Fetch and load together, data wins first, no idle bubble
    nextCycle();
    applyStimulus(1, 8'h08, 1, 0, 8'h20, 8'h00, 0);
    @(negedge clock);
    checkOutput("both_c0_stall", stall, 1'b1);
    nextCycle();
    @(negedge clock);
    checkOutput("both_c1_addr", m_addr, 8'h20);
    checkOutput("both_c1_dready", d_ready, 1'b1);
    checkOutput("both_c1_drdata", d_rdata, 8'h77);
    checkOutput("both_c1_iready", if_ready, 1'b0);
    checkOutput("both_c1_stall", stall, 1'b1);
    nextCycle();
    applyStimulus(1, 8'h08, 0, 0, 8'h20, 8'h00, 0);
    @(negedge clock);
    checkOutput("both_c2_addr", m_addr, 8'h08);
    checkOutput("both_c2_iready", if_ready, 1'b1);
    checkOutput("both_c2_irdata", if_rdata, 8'h99);
    checkOutput("both_c2_stall", stall, 1'b0);
    nextCycle();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0);

    // Store with three busy cycles
    nextCycle();
    for (int c = 0; c <= 4; c++) begin
      applyStimulus(0, 8'h00, 0, 1, 8'h10, 8'hA5, (c >= 1 && c <= 3));
      @(negedge clock);
      checkOutput($sformatf("st_c%0d_write", c), m_write, (c >= 1));
      checkOutput($sformatf("st_c%0d_dready", c), d_ready, (c == 4));
      checkOutput($sformatf("st_c%0d_stall", c), stall, (c <= 3));
      nextCycle();
    end
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    checkOutput("st_mem", devMem[8'h10], 8'hA5);

    // Timeout on a fetch while a load waits; fetch wins (data served last)
    nextCycle();
    for (int c = 0; c <= 4; c++) begin
      applyStimulus(1, 8'h0C, 1, 0, 8'h24, 8'h00, 1);
      @(negedge clock);
      checkOutput($sformatf("to_c%0d_err", c), m_err, (c == 4));
      checkOutput($sformatf("to_c%0d_ready", c), {if_ready, d_ready}, 2'b00);
      if (c >= 1) checkOutput($sformatf("to_c%0d_addr", c), m_addr, 8'h0C);
      nextCycle();
    end
    applyStimulus(1, 8'h0C, 1, 0, 8'h24, 8'h00, 0);
    @(negedge clock);
    checkOutput("to_c5_idle", {m_read, m_write, m_err}, 3'b000);
    nextCycle();
    @(negedge clock);
    checkOutput("to_c6_addr", m_addr, 8'h24);
    checkOutput("to_c6_dready", d_ready, 1'b1);
    checkOutput("to_c6_drdata", d_rdata, 8'h3C);
    nextCycle();
    applyStimulus(1, 8'h0C, 0, 0, 8'h24, 8'h00, 0);
    @(negedge clock);
    checkOutput("to_c7_iready", if_ready, 1'b1);
    checkOutput("to_c7_addr", m_addr, 8'h0C);
    nextCycle();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0);

    // Read and write together: store executes
    nextCycle();
    applyStimulus(0, 8'h00, 1, 1, 8'h40, 8'h5A, 0);
    nextCycle();
    @(negedge clock);
    checkOutput("rw_strobes", {m_write, m_read}, 2'b10);
    checkOutput("rw_wdata", m_wdata, 8'h5A);
    checkOutput("rw_dready", d_ready, 1'b1);
    nextCycle();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    checkOutput("rw_mem", devMem[8'h40], 8'h5A);

    // Reset during a busy data grant; data served last before reset
    nextCycle();
    applyStimulus(0, 8'h00, 1, 0, 8'h30, 8'h00, 1);
    nextCycle();
    @(negedge clock);
    checkOutput("rst_c1_read", m_read, 1'b1);
    reset = 1'b1;
    nextCycle();
    @(negedge clock);
    checkOutput("rst_c2_strobes", {m_read, m_write}, 2'b00);
    checkOutput("rst_c2_dready", d_ready, 1'b0);
    checkOutput("rst_c2_addr", m_addr, 8'h00);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1, 8'h04, 1, 0, 8'h30, 8'h00, 0);
    nextCycle();
    @(negedge clock);
    checkOutput("rst_c3_dready", d_ready, 1'b1);
    checkOutput("rst_c3_addr", m_addr, 8'h30);
    checkOutput("rst_c3_iready", if_ready, 1'b0);
    nextCycle();
    applyStimulus(1, 8'h04, 0, 0, 8'h30, 8'h00, 0);
    @(negedge clock);
    checkOutput("rst_c4_iready", if_ready, 1'b1);
    nextCycle();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, 0);

    // Randomized traffic: fetches from the low half, data in the high half
    nextCycle();
    for (int a = 0; a < 256; a++) refMem[a] = devMem[a];
    busyRun  = 0;
    randMode = 1'b1;
    scoreOn  = 1'b1;
    fork
      begin : fetcher
        int gap;
        int k;
        logic [7:0] fa;
        for (int n = 0; n < 60; n++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) nextCycle();
          fa = 8'($urandom_range(0, 127));
          fetchQ.push_back('{addr: fa, data: refMem[fa], isWrite: 1'b0});
          if_req  = 1'b1;
          if_addr = fa;
          k = 0;
          do begin
            @(negedge clock);
            k++;
          end while (!if_ready && k < 40);
          checkOutput("fetch_handshake", (k < 40), 1'b1);
          nextCycle();
          if_req = 1'b0;
        end
      end
      begin : dataReq
        int gap;
        int k;
        int op;
        logic [7:0] da;
        logic [7:0] dw;
        for (int n = 0; n < 60; n++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) nextCycle();
          op = $urandom_range(0, 2);
          da = 8'($urandom_range(128, 255));
          dw = 8'($urandom);
          if (op != 0) begin
            refMem[da] = dw;
            dataQ.push_back('{addr: da, data: dw, isWrite: 1'b1});
          end else begin
            dataQ.push_back('{addr: da, data: refMem[da], isWrite: 1'b0});
          end
          d_read  = (op != 1);
          d_write = (op != 0);
          d_addr  = da;
          d_wdata = dw;
          k = 0;
          do begin
            @(negedge clock);
            k++;
          end while (!d_ready && k < 40);
          checkOutput("data_handshake", (k < 40), 1'b1);
          nextCycle();
          d_read  = 1'b0;
          d_write = 1'b0;
        end
      end
    join
    repeat (3) nextCycle();
    scoreOn  = 1'b0;
    randMode = 1'b0;
    checkOutput("fetch_left", fetchQ.size(), 0);
    checkOutput("data_left", dataQ.size(), 0);
    for (int a = 128; a < 256; a++) begin
      checkOutput($sformatf("mem_%0h", a), devMem[a], refMem[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and stall sequencer for the 8-bit RISC-V core. It shares one memory/cache port between the instruction-fetch path and the data path (loads and stores from the controller). It drives the port with a registered grant and honours the memory's `busy` handshake. It returns a `stall` signal that the controller uses to freeze `pc` until both requesters are served.

## Interface
Parameters:
- `NBITS`, 8: address and data width.
- `TIMEOUT`, 255: maximum number of consecutive `m_busy` cycles before a grant is aborted. A value of 0 disables the timeout.

Ports:
- `clock` — in, 1: single system clock; all state changes on its rising edge.
- `reset` — in, 1: synchronous, active-high.
- `if_req` — in, 1: fetch request.
- `if_addr` — in, NBITS: fetch address.
- `if_rdata` — out, NBITS: fetched word; valid while `if_ready` is high.
- `if_ready` — out, 1: fetch completes this cycle.
- `d_read` — in, 1: load request.
- `d_write` — in, 1: store request.
- `d_addr` — in, NBITS: data address.
- `d_wdata` — in, NBITS: store data.
- `d_rdata` — out, NBITS: load data; valid while `d_ready` is high.
- `d_ready` — out, 1: data access completes this cycle.
- `m_read` — out, 1: memory read strobe.
- `m_write` — out, 1: memory write strobe.
- `m_addr` — out, NBITS: memory address.
- `m_wdata` — out, NBITS: memory write data.
- `m_rdata` — in, NBITS: memory read data.
- `m_busy` — in, 1: memory not done with the current strobe.
- `stall` — out, 1: some request is pending and not completing this cycle.
- `m_err` — out, 1: one-cycle pulse on a timeout abort.

## Operation
- FSM states: `IDLE`, `GNT_D` (data granted), `GNT_F` (fetch granted).
- `last_d` flag: set when a data grant completes; cleared when a fetch grant completes.
- Data request: `d_req = d_read | d_write`.
- Arbitration (evaluated in `IDLE`, and in a GNT state on its completing cycle):
  - Only one requester pending: that requester is granted.
  - Both pending: fetch wins if `last_d` = 1, otherwise data wins (round-robin).
  - Nothing pending: go to `IDLE`.
- In `GNT_D`: `m_addr` = `d_addr`, `m_wdata` = `d_wdata`.
  - `m_write` = `d_write`; `m_read` = `d_read & ~d_write`.
  - Read and write asserted together: the store executes and the read is ignored.
- In `GNT_F`: `m_addr` = `if_addr`, `m_read` = 1, `m_write` = 0.
- In `IDLE`: all `m_*` outputs are 0.
- Completion: the first cycle in a GNT state with `m_busy` = 0.
  - The matching `*_ready` is 1 for that cycle.
  - `*_rdata` = `m_rdata` (combinational pass-through; both rdata outputs always carry `m_rdata`).
- Requesters hold their request and address stable until ready.
  - If the granted request drops before completion, the FSM goes to `IDLE` next cycle.
  - No ready is issued, and `last_d` is unchanged.
- Wait counter:
  - Counts consecutive `m_busy` cycles in a GNT state; cleared on every grant change.
  - When it reaches `TIMEOUT` with `TIMEOUT` > 0: pulse `m_err`, go to `IDLE`, issue no ready, and toggle `last_d` so the other requester gets the next grant.
- Stall: `stall = (d_req & ~d_ready) | (if_req & ~if_ready)`.

## Timing
- Reset values: state = `IDLE`, `last_d` = 0, counter = 0.
  - Hence `m_read`/`m_write`/`m_addr`/`m_wdata` = 0, ready outputs = 0, `m_err` = 0.
  - `stall` follows the requests combinationally.
- Reset mid-grant: strobes are 0 from the cycle after the reset edge. An in-flight access is dropped without ready.
- Grant latency: a request first seen at edge N is granted (state updated) at edge N; strobes are active in cycle N+1.
  - Minimum latency is 1 cycle plus the number of busy cycles.
- Back-to-back: on a completing cycle with the other requester pending, the next grant starts the following cycle, with no `IDLE` bubble.
- Fetch and data both requesting from `IDLE` with `last_d` = 0: data completes first (cycle 1), fetch completes cycle 2 at the earliest.
- `m_err` and a ready are never high in the same cycle.
- Counter width: `$clog2(TIMEOUT+1)`, saturating. A busy run of exactly `TIMEOUT` cycles aborts; `TIMEOUT`−1 busy cycles followed by a not-busy cycle completes normally.

## Structure
- Package `mem_arbiter_pkg`:
  - `typedef enum logic [1:0] {IDLE, GNT_D, GNT_F} arb_state_t`.
  - Constants for the grant encoding, shared with the controller's stall logic.
- No sub-module needed.
  - FSM, `last_d`, and wait counter live in one `always_ff`.
  - Port muxing and ready/stall generation live in one `always_comb`.

## Test plan
- Reset, then `if_req`=1, `if_addr`=0x04, `m_busy`=0, `m_rdata`=0x13 → cycle 1: `m_read`=1, `m_addr`=0x04, `if_ready`=1, `if_rdata`=0x13, `stall`=0.
- `if_req` and `d_read` together from `IDLE`, `last_d`=0, `d_addr`=0x20 → `GNT_D` first, then `GNT_F` with no idle cycle; `stall`=1 until cycle 2.
- Store `d_write`=1, `d_addr`=0x10, `d_wdata`=0xA5, `m_busy` high 3 cycles → `m_write` held 4 cycles; `d_ready` on cycle 4 only; `stall` high cycles 0–3.
- `TIMEOUT`=4, `m_busy` stuck 1 during a fetch → `m_err` pulses on the 4th busy cycle; FSM returns to `IDLE`; `if_ready` never asserts; a pending data request is granted next.
- Reset asserted during `GNT_D` with `m_busy`=1 → strobes 0 the next cycle; no `d_ready`; `last_d`=0.
- `d_read` and `d_write` both 1 → `m_write`=1, `m_read`=0.
